ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001: Parameter MEM_WORDS, default 1024, storage depth in 32-bit words; SHALL be a power of two, 16..65536.
REQ-002: Parameter WAIT_STATES, default 1, data-phase wait cycles per transfer; SHALL be in the range 0..7.
REQ-003: clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: rst_i  input  1  reset; synchronous, active-high.
REQ-005: HSEL  input  1  slave select from the address decoder.
REQ-006: HADDR  input  32  byte address, sampled in the address phase.
REQ-007: HTRANS  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008: HSIZE  input  3  transfer size: 000 byte, 001 halfword, 010 word.
REQ-009: HWRITE  input  1  1 = write, 0 = read.
REQ-010: HWDATA  input  32  write data, valid in the data phase.
REQ-011: HREADY  input  1  bus-level ready; gates address-phase acceptance.
REQ-012: HREADYOUT  output  1  slave ready; low stalls the current data phase.
REQ-013: HRDATA  output  32  read data.
REQ-014: HRESP  output  1  0 = OKAY, 1 = ERROR.

Function
REQ-015: A transfer SHALL be accepted on a rising edge where HSEL=1, HTRANS[1]=1 and HREADY=1.
REQ-016: On acceptance the block SHALL register word index HADDR[log2(MEM_WORDS)+1:2], HADDR[1:0], HSIZE and HWRITE.
REQ-017: States: IDLE, WAIT and DONE, plus ERR1 and ERR2 only when AHB_SRAM_ERR_EN is defined.
REQ-018: Acceptance with WAIT_STATES>0 SHALL go to WAIT and load the wait counter with WAIT_STATES-1; acceptance with WAIT_STATES=0 SHALL go directly to DONE.
REQ-019: In WAIT, HREADYOUT SHALL be 0; the counter SHALL decrement each cycle and the state SHALL move to DONE when the counter reaches 0.
REQ-020: In DONE, HREADYOUT SHALL be 1 for exactly one cycle. A new acceptance in that cycle SHALL restart the sequence back-to-back; otherwise the state SHALL return to IDLE.
REQ-021: In IDLE, and for HTRANS IDLE/BUSY or HSEL=0, HREADYOUT SHALL be 1 and HRESP SHALL be 0 with no memory access (zero-wait OKAY).
REQ-022: Byte-lane mask:
- size 000: 4'b0001 << HADDR[1:0].
- size 001: 4'b0011 if HADDR[1]=0, else 4'b1100.
- size 010: 4'b1111.
REQ-023: A write SHALL update only the masked byte lanes from the matching HWDATA lanes, on the clock edge that ends the DONE cycle.
REQ-024: During the DONE cycle of a read, HRDATA SHALL be the full stored word at the registered index (the master extracts lanes); at all other times HRDATA SHALL be 0.
REQ-025: A read in the data phase immediately after a write to the same word SHALL return the newly written bytes.
REQ-026: Total transfer latency SHALL be WAIT_STATES+1 data-phase cycles.

Reset
REQ-027: While rst_i=1 the outputs SHALL be HREADYOUT=1, HRESP=0 and HRDATA=0; the state SHALL be IDLE and the wait counter 0.
REQ-028: Memory contents SHALL NOT be reset.
REQ-029: Reset asserted mid-transfer (WAIT, DONE or ERRx) SHALL abandon that transfer with no memory write.

Configuration
REQ-030: Macro AHB_SRAM_ERR_EN.
REQ-031: With AHB_SRAM_ERR_EN defined:
- An accepted transfer with HADDR[31:log2(MEM_WORDS)+2] nonzero, or with HSIZE>010, SHALL go to ERR1 instead of WAIT/DONE.
- ERR1 SHALL drive HREADYOUT=0, HRESP=1.
- ERR2 SHALL drive HREADYOUT=1, HRESP=1, then return to IDLE.
- No memory access SHALL occur for an errored transfer.
REQ-032: Without AHB_SRAM_ERR_EN:
- Upper address bits SHALL be ignored (address wraps).
- HSIZE>010 SHALL be treated as a word access.
- HRESP SHALL be tied 0.

Verification
REQ-033: WAIT_STATES=1; word write 0xDEADBEEF to 0x10, then word read of 0x10 -> each transfer shows HREADYOUT low 1 cycle then high; read HRDATA=0xDEADBEEF in its DONE cycle.
REQ-034: Byte write 0xAA to 0x13 over stored word 0x11223344 -> readback 0xAA223344.
REQ-035: WAIT_STATES=0; three back-to-back NONSEQ word reads -> HREADYOUT held 1, one data word per cycle.
REQ-036: AHB_SRAM_ERR_EN defined, MEM_WORDS=1024; write to 0x00001000 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); word 0 unchanged.
REQ-037: WAIT_STATES=3; rst_i asserted during the 2nd wait cycle of a write -> next cycle HREADYOUT=1, HRESP=0; target word unchanged.
REQ-038: HSEL=1 with HTRANS=01 (BUSY) -> HREADYOUT=1, HRESP=0, no memory access.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle for ahb_sram_slave.
// master modport: drives address/control/write data, observes slave response.
// slave  modport: receives address/control/write data and bus HREADY,
//                 drives HREADYOUT, HRDATA, HRESP.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with a fixed number of data-phase wait states.
// Ports:
//   clk_i  - single clock, rising edge
//   rst_i  - synchronous active-high reset (memory contents are kept)
//   bus    - ahb_sram_slave_if.slave (HSEL/HADDR/HTRANS/HSIZE/HWRITE/HWDATA/
//            HREADY in; HREADYOUT/HRDATA/HRESP out)
// Parameters:
//   MEM_WORDS   - depth in 32-bit words, power of two, 16..65536
//   WAIT_STATES - data-phase wait cycles per transfer, 0..7
// Optional feature macro: AHB_SRAM_ERR_EN
//   defined   - out-of-range address or HSIZE>word gives a two-cycle ERROR
//   undefined - upper address bits ignored (wrap), HSIZE>word acts as word,
//               HRESP tied low
module ahb_sram_slave #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ahb_sram_slave_if.slave   bus
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
`ifdef AHB_SRAM_ERR_EN
    ,
    ST_ERR1,
    ST_ERR2
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [1:0]     off_q, off_d;
  logic [2:0]     size_q, size_d;
  logic           wr_q, wr_d;

  logic [31:0]    mem_q [MEM_WORDS];
  logic [31:0]    mem_wdata_d;
  logic           mem_we;
  logic [3:0]     lane_mask;
  logic           accept;
  logic           xfer_err;
  logic           hready_c;
  logic           hresp_c;

  // New address phases are only taken when no data phase is stalled.
  assign accept = bus.HSEL && bus.HTRANS[1] && bus.HREADY &&
                  ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef AHB_SRAM_ERR_EN
  assign xfer_err = (bus.HADDR[31:AW+2] != '0) || (bus.HSIZE > 3'b010);
  logic unused_bits;
  assign unused_bits = bus.HTRANS[0];
`else
  assign xfer_err = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{bus.HTRANS[0], bus.HADDR[31:AW+2]};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    off_d    = off_q;
    size_d   = size_q;
    wr_d     = wr_q;
    hready_c = 1'b1;
    hresp_c  = 1'b0;

    case (state_q)
      ST_WAIT: begin
        hready_c = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
`ifdef AHB_SRAM_ERR_EN
      ST_ERR1: begin
        hready_c = 1'b0;
        hresp_c  = 1'b1;
        state_d  = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_c = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Acceptance in DONE overrides the return to IDLE (back-to-back).
    if (accept) begin
      idx_d  = bus.HADDR[AW+1:2];
      off_d  = bus.HADDR[1:0];
      size_d = bus.HSIZE;
      wr_d   = bus.HWRITE;
      cnt_d  = '0;
      if (xfer_err) begin
`ifdef AHB_SRAM_ERR_EN
        state_d = ST_ERR1;
`endif
      end else if (WAIT_STATES == 0) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = 3'(WAIT_STATES - 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    case (size_q)
      3'b000:  lane_mask = 4'b0001 << off_q;
      3'b001:  lane_mask = off_q[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // Read-modify-write of the addressed word keeps unmasked lanes intact.
  always_comb begin
    mem_wdata_d = mem_q[idx_q];
    for (int unsigned i = 0; i < 4; i++) begin
      if (lane_mask[i]) begin
        mem_wdata_d[8*i +: 8] = bus.HWDATA[8*i +: 8];
      end
    end
  end

  // Reset in the DONE cycle suppresses the write, abandoning the transfer.
  assign mem_we = (state_q == ST_DONE) && wr_q && !rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx_q] <= mem_wdata_d;
    end
  end

  assign bus.HREADYOUT = rst_i ? 1'b1 : hready_c;
  assign bus.HRESP     = rst_i ? 1'b0 : hresp_c;
  assign bus.HRDATA    = ((state_q == ST_DONE) && !wr_q && !rst_i) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed self-checking bench for ahb_sram_slave. Three instances share one
// set of bus inputs (each with its own HSEL): k=0 WAIT_STATES=1,
// k=1 WAIT_STATES=0, k=2 WAIT_STATES=3. Each instance's HREADY is its own
// HREADYOUT, as on a single-slave bus.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ahb_sram_slave_if bus_w1 ();
  ahb_sram_slave_if bus_w0 ();
  ahb_sram_slave_if bus_w3 ();

  assign bus_w1.HSEL = hsel[0];
  assign bus_w0.HSEL = hsel[1];
  assign bus_w3.HSEL = hsel[2];
  assign bus_w1.HADDR = haddr;   assign bus_w0.HADDR = haddr;   assign bus_w3.HADDR = haddr;
  assign bus_w1.HTRANS = htrans; assign bus_w0.HTRANS = htrans; assign bus_w3.HTRANS = htrans;
  assign bus_w1.HSIZE = hsize;   assign bus_w0.HSIZE = hsize;   assign bus_w3.HSIZE = hsize;
  assign bus_w1.HWRITE = hwrite; assign bus_w0.HWRITE = hwrite; assign bus_w3.HWRITE = hwrite;
  assign bus_w1.HWDATA = hwdata; assign bus_w0.HWDATA = hwdata; assign bus_w3.HWDATA = hwdata;
  assign bus_w1.HREADY = bus_w1.HREADYOUT;
  assign bus_w0.HREADY = bus_w0.HREADYOUT;
  assign bus_w3.HREADY = bus_w3.HREADYOUT;

  ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(1)) dut_w1 (.clk_i(clk), .rst_i(rst), .bus(bus_w1));
  ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0)) dut_w0 (.clk_i(clk), .rst_i(rst), .bus(bus_w0));
  ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(3)) dut_w3 (.clk_i(clk), .rst_i(rst), .bus(bus_w3));

  function automatic logic [31:0] get_rdy(input int k);
    case (k)
      0:       return {31'b0, bus_w1.HREADYOUT};
      1:       return {31'b0, bus_w0.HREADYOUT};
      default: return {31'b0, bus_w3.HREADYOUT};
    endcase
  endfunction

  function automatic logic [31:0] get_resp(input int k);
    case (k)
      0:       return {31'b0, bus_w1.HRESP};
      1:       return {31'b0, bus_w0.HRESP};
      default: return {31'b0, bus_w3.HRESP};
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int k);
    case (k)
      0:       return bus_w1.HRDATA;
      1:       return bus_w0.HRDATA;
      default: return bus_w3.HRDATA;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    hsel   = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b010;
  endtask

  // Single non-pipelined transfer; entered and left just after a rising edge.
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input int exp_w, input string tag);
    int w;
    bit done;
    hsel    = '0;
    hsel[k] = 1'b1;
    htrans  = 2'b10;
    haddr   = addr;
    hsize   = size;
    hwrite  = wr;
    @(posedge clk); #1;
    bus_idle();
    hwdata = wd;
    w    = 0;
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (get_rdy(k) == 32'd1) done = 1'b1;
      else w++;
    end
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_waits"}, 32'(w), 32'(exp_w));
    check({tag, "_resp"}, get_resp(k), 32'd0);
    if (!wr) check({tag, "_rdata"}, get_rdata(k), exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    haddr  = '0;
    hwdata = '0;
    bus_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_rdy", get_rdy(k), 32'd1);
      check("rst_resp", get_resp(k), 32'd0);
      check("rst_rdata", get_rdata(k), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_rdy", get_rdy(0), 32'd1);
    @(posedge clk); #1;

    // WAIT_STATES=1: word write/read, then byte and halfword lane merges
    xfer(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1, "w1_wr");
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1, "w1_rd");
    @(negedge clk);
    check("w1_rdata_idle", get_rdata(0), 32'd0);
    @(posedge clk); #1;
    xfer(0, 1'b1, 32'h10, 3'b010, 32'h11223344, 32'h0, 1, "w1_wr2");
    xfer(0, 1'b1, 32'h13, 3'b000, 32'hAA000000, 32'h0, 1, "w1_bwr");
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, 32'hAA223344, 1, "w1_brd");

    // BUSY with HSEL=1: zero-wait OKAY and no memory access
    hsel[0] = 1'b1; htrans = 2'b01; hwrite = 1'b1; haddr = 32'h10; hsize = 3'b010;
    hwdata  = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("busy_rdy", get_rdy(0), 32'd1);
    check("busy_resp", get_resp(0), 32'd0);
    check("busy_rdata", get_rdata(0), 32'd0);
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, 32'hAA223344, 1, "busy_rd");

    xfer(0, 1'b1, 32'h14, 3'b010, 32'h11223344, 32'h0, 1, "w1_wr3");
    xfer(0, 1'b1, 32'h16, 3'b001, 32'h66550000, 32'h0, 1, "w1_hwr");
    xfer(0, 1'b0, 32'h14, 3'b010, 32'h0, 32'h66553344, 1, "w1_hrd");
    xfer(0, 1'b1, 32'h15, 3'b000, 32'h0000BB00, 32'h0, 1, "w1_bwr2");
    xfer(0, 1'b0, 32'h14, 3'b010, 32'h0, 32'h6655BB44, 1, "w1_brd2");

`ifdef AHB_SRAM_ERR_EN
    xfer(0, 1'b1, 32'h0, 3'b010, 32'h12345678, 32'h0, 1, "e_wr0");
    hsel[0] = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h00001000; hsize = 3'b010;
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'h87654321;
    @(negedge clk);
    check("err1_rdy", get_rdy(0), 32'd0);
    check("err1_resp", get_resp(0), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("err2_rdy", get_rdy(0), 32'd1);
    check("err2_resp", get_resp(0), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("err_end_resp", get_resp(0), 32'd0);
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h0, 3'b010, 32'h0, 32'h12345678, 1, "e_rd0");
`else
    xfer(0, 1'b1, 32'h18, 3'b011, 32'hCAFEF00D, 32'h0, 1, "sz3_wr");
    xfer(0, 1'b0, 32'h18, 3'b010, 32'h0, 32'hCAFEF00D, 1, "sz3_rd");
    xfer(0, 1'b0, 32'h1010, 3'b010, 32'h0, 32'hAA223344, 1, "wrap_rd");
`endif

    // WAIT_STATES=0: preload, three back-to-back reads, write-then-read
    xfer(1, 1'b1, 32'h40, 3'b010, 32'h01010101, 32'h0, 0, "w0_wa");
    xfer(1, 1'b1, 32'h44, 3'b010, 32'h02020202, 32'h0, 0, "w0_wb");
    xfer(1, 1'b1, 32'h48, 3'b010, 32'h03030303, 32'h0, 0, "w0_wc");
    hsel[1] = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010; haddr = 32'h40;
    @(posedge clk); #1;
    haddr = 32'h44;
    @(negedge clk);
    check("b2b_rdy0", get_rdy(1), 32'd1);
    check("b2b_d0", get_rdata(1), 32'h01010101);
    @(posedge clk); #1;
    haddr = 32'h48;
    @(negedge clk);
    check("b2b_rdy1", get_rdy(1), 32'd1);
    check("b2b_d1", get_rdata(1), 32'h02020202);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("b2b_rdy2", get_rdy(1), 32'd1);
    check("b2b_d2", get_rdata(1), 32'h03030303);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_idle", get_rdata(1), 32'd0);
    @(posedge clk); #1;

    hsel[1] = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h4C;
    @(posedge clk); #1;
    hwrite = 1'b0;
    hwdata = 32'h0BADF00D;
    @(negedge clk);
    check("raw_rdy", get_rdy(1), 32'd1);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("raw_rdata", get_rdata(1), 32'h0BADF00D);
    @(posedge clk); #1;

    // WAIT_STATES=3: reset in the 2nd wait cycle abandons the write
    xfer(2, 1'b1, 32'h20, 3'b010, 32'h55555555, 32'h0, 3, "w3_wr");
    hsel[2] = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h20;
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'h99999999;
    @(negedge clk);
    check("w3_wait1", get_rdy(2), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_rdy", get_rdy(2), 32'd1);
    check("mrst_resp", get_resp(2), 32'd0);
    check("mrst_rdata", get_rdata(2), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    xfer(2, 1'b0, 32'h20, 3'b010, 32'h0, 32'h55555555, 3, "mrst_rd");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
